// File: rtl/sm_data_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : sm_data_bus_pkg                                            |
// | Brief  : MMIO address map, TMR_CTRL bit indices and address decode  |
// |          shared by the data-bus top and the timer.                  |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
package sm_data_bus_pkg;

  localparam logic [31:0] SM_DB_GPIO_OUT = 32'hFFFF_0000;
  localparam logic [31:0] SM_DB_GPIO_IN  = 32'hFFFF_0004;
  localparam logic [31:0] SM_DB_TMR_CNT  = 32'hFFFF_0008;
  localparam logic [31:0] SM_DB_TMR_CMP  = 32'hFFFF_000C;
  localparam logic [31:0] SM_DB_TMR_PRE  = 32'hFFFF_0010;
  localparam logic [31:0] SM_DB_TMR_CTRL = 32'hFFFF_0014;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AR   = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_FLAG = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO_OUT,
    SEL_GPIO_IN,
    SEL_TMR_CNT,
    SEL_TMR_CMP,
    SEL_TMR_PRE,
    SEL_TMR_CTRL
  } sel_e;

  // Full 32-bit compare on the word address; byte offset bits are ignored.
  function automatic sel_e decode(input logic [31:0] addr, input int ram_aw);
    logic [31:0] word;
    word = {addr[31:2], 2'b00};
    if ((addr >> (ram_aw + 2)) == 32'd0) return SEL_RAM;
    case (word)
      SM_DB_GPIO_OUT: return SEL_GPIO_OUT;
      SM_DB_GPIO_IN:  return SEL_GPIO_IN;
      SM_DB_TMR_CNT:  return SEL_TMR_CNT;
      SM_DB_TMR_CMP:  return SEL_TMR_CMP;
      SM_DB_TMR_PRE:  return SEL_TMR_PRE;
      SM_DB_TMR_CTRL: return SEL_TMR_CTRL;
      default:        return SEL_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_data_bus_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : sm_data_bus_if                                             |
// | Brief  : M-stage data-memory bus: address, write strobe, write and  |
// |          same-cycle read data.                                      |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
interface sm_data_bus_if;
  logic [31:0] dmAddr;
  logic        dmWe;
  logic [31:0] dmWData;
  logic [31:0] dmRData;

  modport master (output dmAddr, output dmWe, output dmWData, input  dmRData);
  modport slave  (input  dmAddr, input  dmWe, input  dmWData, output dmRData);
endinterface
`default_nettype wire

// File: rtl/sm_data_bus_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : sm_data_bus_timer                                          |
// | Brief  : Prescaled 32-bit timer with compare, autoreload, sticky    |
// |          match flag (write-1-to-clear) and interrupt.               |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
module sm_data_bus_timer
  import sm_data_bus_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  sel_e        sel,
  input  logic [31:0] wdata,
  output logic [31:0] cnt_rd,
  output logic [31:0] cmp_rd,
  output logic [31:0] pre_rd,
  output logic [31:0] ctrl_rd,
  output logic        irq
);

  logic [31:0]        r_cnt;
  logic [31:0]        r_cmp;
  logic [PRESC_W-1:0] r_pre;
  logic [PRESC_W-1:0] r_presc;
  logic               r_en, r_ar, r_ie, r_flag;

  logic w_cnt_we, w_cmp_we, w_pre_we, w_ctrl_we;
  logic w_en_now, w_tick, w_match;

  assign w_cnt_we  = we && (sel == SEL_TMR_CNT);
  assign w_cmp_we  = we && (sel == SEL_TMR_CMP);
  assign w_pre_we  = we && (sel == SEL_TMR_PRE);
  assign w_ctrl_we = we && (sel == SEL_TMR_CTRL);

  // Clearing en acts on the same edge; setting en only counts from the next edge
  // because the enable register is still 0 during the writing cycle.
  assign w_en_now = r_en && !(w_ctrl_we && !wdata[CTRL_EN]);
  assign w_tick   = w_en_now && (r_presc == r_pre);
  // A CPU write to CNT owns that edge: no match is evaluated.
  assign w_match  = w_tick && !w_cnt_we && (r_cnt == r_cmp);

  // Prescaler: counts 0..PRE, wraps on tick, restarts whenever PRE is written.
  always_ff @(posedge clk) begin
    if (rst)               r_presc <= '0;
    else if (w_pre_we)     r_presc <= '0;
    else if (w_en_now)     r_presc <= w_tick ? '0 : r_presc + 1'b1;
  end

  // Counter: CPU write wins, otherwise increment or reload on tick.
  always_ff @(posedge clk) begin
    if (rst)               r_cnt <= '0;
    else if (w_cnt_we)     r_cnt <= wdata;
    else if (w_tick)       r_cnt <= (w_match && r_ar) ? 32'd0 : r_cnt + 32'd1;
  end

  // Software-visible configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp <= '0;
      r_pre <= '0;
      r_en  <= 1'b0;
      r_ar  <= 1'b0;
      r_ie  <= 1'b0;
    end else begin
      if (w_cmp_we) r_cmp <= wdata;
      if (w_pre_we) r_pre <= wdata[PRESC_W-1:0];
      if (w_ctrl_we) begin
        r_en <= wdata[CTRL_EN];
        r_ar <= wdata[CTRL_AR];
        r_ie <= wdata[CTRL_IE];
      end
    end
  end

  // Sticky match flag; a set on the same edge as a W1C wins.
  always_ff @(posedge clk) begin
    if (rst)                                r_flag <= 1'b0;
    else if (w_match)                       r_flag <= 1'b1;
    else if (w_ctrl_we && wdata[CTRL_FLAG]) r_flag <= 1'b0;
  end

  // Assemble the CTRL read view.
  always_comb begin
    ctrl_rd            = '0;
    ctrl_rd[CTRL_EN]   = r_en;
    ctrl_rd[CTRL_AR]   = r_ar;
    ctrl_rd[CTRL_IE]   = r_ie;
    ctrl_rd[CTRL_FLAG] = r_flag;
  end

  assign cnt_rd = r_cnt;
  assign cmp_rd = r_cmp;
  assign pre_rd = 32'(r_pre);
  assign irq    = r_ie & r_flag;

endmodule
`default_nettype wire

// File: rtl/sm_data_bus.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : sm_data_bus                                                |
// | Brief  : Data-side memory system: word RAM, GPIO and timer MMIO,    |
// |          zero-latency read mux for the M stage.                     |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
module sm_data_bus
  import sm_data_bus_pkg::*;
#(
  parameter int RAM_AW  = 6,
  parameter int GPIO_W  = 16,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  sm_data_bus_if.slave      bus,
  input  logic [GPIO_W-1:0] gpioIn,
  output logic [GPIO_W-1:0] gpioOut,
  output logic              irq
);

  sel_e              w_sel;
  logic [RAM_AW-1:0] w_idx;
  logic [31:0]       r_mem [0:(2**RAM_AW)-1];
  logic [GPIO_W-1:0] r_gpio_out;
  logic [GPIO_W-1:0] r_sync1, r_sync2;
  logic [31:0]       w_cnt_rd, w_cmp_rd, w_pre_rd, w_ctrl_rd;

  assign w_sel = decode(bus.dmAddr, RAM_AW);
  assign w_idx = bus.dmAddr[RAM_AW+1:2];

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.dmWe && (w_sel == SEL_RAM)) r_mem[w_idx] <= bus.dmWData;
  end

  // GPIO output register.
  always_ff @(posedge clk) begin
    if (rst)                                    r_gpio_out <= '0;
    else if (bus.dmWe && (w_sel == SEL_GPIO_OUT)) r_gpio_out <= bus.dmWData[GPIO_W-1:0];
  end

  // Two-flop synchronizer for the asynchronous GPIO inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpioIn;
      r_sync2 <= r_sync1;
    end
  end

  sm_data_bus_timer #(.PRESC_W(PRESC_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.dmWe),
    .sel     (w_sel),
    .wdata   (bus.dmWData),
    .cnt_rd  (w_cnt_rd),
    .cmp_rd  (w_cmp_rd),
    .pre_rd  (w_pre_rd),
    .ctrl_rd (w_ctrl_rd),
    .irq     (irq)
  );

  // Combinational read mux; unmapped addresses read as zero.
  always_comb begin
    bus.dmRData = '0;
    case (w_sel)
      SEL_RAM:      bus.dmRData = r_mem[w_idx];
      SEL_GPIO_OUT: bus.dmRData = 32'(r_gpio_out);
      SEL_GPIO_IN:  bus.dmRData = 32'(r_sync2);
      SEL_TMR_CNT:  bus.dmRData = w_cnt_rd;
      SEL_TMR_CMP:  bus.dmRData = w_cmp_rd;
      SEL_TMR_PRE:  bus.dmRData = w_pre_rd;
      SEL_TMR_CTRL: bus.dmRData = w_ctrl_rd;
      default:      bus.dmRData = '0;
    endcase
  end

  assign gpioOut = r_gpio_out;

endmodule
`default_nettype wire

// File: tb/tb_sm_data_bus.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_sm_data_bus                                             |
// | Brief  : Directed self-checking bench for sm_data_bus.              |
// | Rev    : 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_sm_data_bus;

  localparam logic [31:0] A_GPO  = 32'hFFFF_0000;
  localparam logic [31:0] A_GPI  = 32'hFFFF_0004;
  localparam logic [31:0] A_CNT  = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP  = 32'hFFFF_000C;
  localparam logic [31:0] A_PRE  = 32'hFFFF_0010;
  localparam logic [31:0] A_CTRL = 32'hFFFF_0014;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;
  int          checks = 0;
  int          errors = 0;

  sm_data_bus_if bus ();

  sm_data_bus #(.RAM_AW(6), .GPIO_W(16), .PRESC_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .gpioIn  (gpio_in),
    .gpioOut (gpio_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus write committed at the next posedge; returns 1 time unit after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.dmAddr  = a;
    bus.dmWData = d;
    bus.dmWe    = 1'b1;
    @(posedge clk);
    #1;
    bus.dmWe    = 1'b0;
  endtask

  // Combinational read check, consumes 1 time unit.
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus.dmAddr = a;
    bus.dmWe   = 1'b0;
    #1;
    chk(tag, bus.dmRData, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    gpio_in = '0;
    bus.dmAddr = '0;
    bus.dmWe = 1'b0;
    bus.dmWData = '0;
    cycles(3);
    rst = 1'b0;

    // Reset state
    chk("rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rd(A_CNT, 32'h0, "rst_cnt");
    rd(A_CTRL, 32'h0, "rst_ctrl");

    // RAM write then read, byte offset ignored
    wr(32'h0000_0000, 32'hCAFE_F00D);
    wr(32'h0000_0010, 32'h1234_5678);
    rd(32'h0000_0010, 32'h1234_5678, "ram_rd10");
    rd(32'h0000_0013, 32'h1234_5678, "ram_rd13");

    // Unmapped write ignored, reads zero
    wr(32'hFFFF_0040, 32'hDEAD_BEEF);
    rd(32'hFFFF_0040, 32'h0, "unmapped_rd");
    rd(32'h0000_0000, 32'hCAFE_F00D, "ram_rd0_kept");

    // GPIO input through the synchronizer, GPIO output register
    gpio_in = 16'h00A5;
    cycles(1);
    rd(A_GPI, 32'h0, "gpi_n1");
    cycles(1);
    rd(A_GPI, 32'h0000_00A5, "gpi_n2");
    wr(A_GPO, 32'h1234_BEEF);
    chk("gpo_pin", 32'(gpio_out), 32'h0000_BEEF);
    rd(A_GPO, 32'h0000_BEEF, "gpo_rd_upper0");

    // Timer: PRE=3, CMP=2, autoreload + ie + en
    wr(A_PRE, 32'd3);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h7);
    rd(A_CNT, 32'd0, "tmr_cnt_e0");
    cycles(3);
    rd(A_CNT, 32'd0, "tmr_cnt_e3");
    cycles(1);
    rd(A_CNT, 32'd1, "tmr_cnt_e4");
    cycles(4);
    rd(A_CNT, 32'd2, "tmr_cnt_e8");
    rd(A_CTRL, 32'h007, "tmr_ctrl_e8");
    chk("tmr_irq_e8", 32'(irq), 32'h0);
    cycles(4);
    rd(A_CNT, 32'd0, "tmr_cnt_reload");
    rd(A_CTRL, 32'h107, "tmr_flag_set");
    chk("tmr_irq_set", 32'(irq), 32'h1);
    wr(A_CTRL, 32'h107);
    rd(A_CTRL, 32'h007, "tmr_w1c");
    chk("tmr_irq_clr", 32'(irq), 32'h0);

    // Collisions: CNT write during a tick, match plus W1C
    wr(A_CTRL, 32'h106);
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd7);
    wr(A_CNT, 32'd5);
    wr(A_CTRL, 32'h007);
    rd(A_CNT, 32'd5, "col_en_no_tick");
    wr(A_CNT, 32'd7);
    rd(A_CNT, 32'd7, "col_cnt_wr_tick");
    rd(A_CTRL, 32'h007, "col_no_match_on_wr");
    wr(A_CTRL, 32'h107);
    rd(A_CTRL, 32'h107, "col_set_wins");
    chk("col_irq", 32'(irq), 32'h1);
    rd(A_CNT, 32'd0, "col_reload");
    wr(A_CNT, 32'hABCD_0000);
    rd(A_CNT, 32'hABCD_0000, "col_cnt_wr2");

    // Disable on write edge, hold while disabled, then wrap without flag
    wr(A_CTRL, 32'h106);
    rd(A_CTRL, 32'h006, "dis_ctrl");
    rd(A_CNT, 32'hABCD_0000, "dis_no_tick");
    wr(A_CNT, 32'hFFFF_FFFF);
    wr(A_CMP, 32'd5);
    cycles(2);
    rd(A_CNT, 32'hFFFF_FFFF, "dis_hold");
    wr(A_CTRL, 32'h001);
    rd(A_CNT, 32'hFFFF_FFFF, "wrap_pre");
    cycles(1);
    rd(A_CNT, 32'd0, "wrap_zero");
    rd(A_CTRL, 32'h001, "wrap_no_flag");
    cycles(6);
    rd(A_CNT, 32'd6, "norel_cnt");
    rd(A_CTRL, 32'h101, "norel_flag");
    chk("norel_irq_ie0", 32'(irq), 32'h0);
    wr(A_CTRL, 32'h005);
    chk("ie_irq", 32'(irq), 32'h1);

    // Reset mid-count: MMIO cleared, RAM kept
    rst = 1'b1;
    cycles(1);
    rd(A_CNT, 32'h0, "mrst_cnt");
    rd(A_CMP, 32'h0, "mrst_cmp");
    rd(A_PRE, 32'h0, "mrst_pre");
    rd(A_CTRL, 32'h0, "mrst_ctrl");
    cycles(1);
    rd(A_GPO, 32'h0, "mrst_gpo");
    rd(A_GPI, 32'h0, "mrst_gpi");
    chk("mrst_irq", 32'(irq), 32'h0);
    chk("mrst_gpo_pin", 32'(gpio_out), 32'h0);
    rd(32'h0000_0010, 32'h1234_5678, "mrst_ram10");
    rd(32'h0000_0000, 32'hCAFE_F00D, "mrst_ram0");
    rst = 1'b0;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
